// File: rtl/note_sequencer.sv
// Song sequencer: walks a 1-cycle synchronous note ROM and times each note through an external delay block.
// All outputs are registered from next-state values except busy, which is decoded from the state register.
module note_sequencer #(
  parameter int WIDTH  = 11,
  parameter int NOTE_W = 4,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+WIDTH-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_valid,
  output logic [WIDTH-1:0]        duration,
  output logic                    delay_enabled,
  input  logic                    delay_active,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, REST} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [NOTE_W-1:0]   note_nxt;
  logic [WIDTH-1:0]    dur_nxt;
  logic                en_nxt, nv_nxt, done_nxt;
  logic [NOTE_W-1:0]   rom_note;
  logic [WIDTH-1:0]    rom_dur;

  assign rom_note = rom_data[NOTE_W+WIDTH-1:WIDTH];
  assign rom_dur  = rom_data[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    note_nxt  = note;
    dur_nxt   = duration;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        note_nxt = rom_note;
        dur_nxt  = rom_dur;
        if (rom_dur == '0) begin
          // A marker at address 0 always ends the song, so an empty song cannot loop forever.
          if (loop && (rom_addr != '0)) begin
            addr_nxt  = '0;
            state_nxt = FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (!delay_active) state_nxt = REST;
      end
      REST: begin
        addr_nxt  = rom_addr + ADDR_W'(1);
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      note_nxt  = '0;
      dur_nxt   = '0;
      done_nxt  = 1'b0;
    end
    en_nxt = (state_nxt == PLAY);
    nv_nxt = (state_nxt == PLAY) && (note_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rom_addr      <= '0;
      note          <= '0;
      duration      <= '0;
      delay_enabled <= 1'b0;
      note_valid    <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      rom_addr      <= addr_nxt;
      note          <= note_nxt;
      duration      <= dur_nxt;
      delay_enabled <= en_nxt;
      note_valid    <= nv_nxt;
      done          <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: two sequencers (ADDR_W=6 and ADDR_W=2), each with a synchronous ROM and a PREDIV=4 delay model.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [5:0]  rom_addr;
  logic [14:0] rom_data = '0;
  logic [3:0]  note;
  logic        note_valid;
  logic [10:0] duration;
  logic        delay_enabled, delay_active;
  logic        busy, done;

  logic        start2 = 1'b0, stop2 = 1'b0;
  logic [1:0]  rom_addr2;
  logic [14:0] rom_data2 = '0;
  logic [3:0]  note2;
  logic        note_valid2;
  logic [10:0] duration2;
  logic        delay_enabled2, delay_active2;
  logic        busy2, done2;

  logic [14:0] mem  [0:63];
  logic [14:0] mem2 [0:3];
  logic [12:0] dcnt, dcnt2;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int base;

  always #5 clk = ~clk;

  note_sequencer #(.WIDTH(11), .NOTE_W(4), .ADDR_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .note_valid(note_valid),
    .duration(duration), .delay_enabled(delay_enabled), .delay_active(delay_active),
    .busy(busy), .done(done)
  );

  note_sequencer #(.WIDTH(11), .NOTE_W(4), .ADDR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop2), .loop(1'b0),
    .rom_addr(rom_addr2), .rom_data(rom_data2), .note(note2), .note_valid(note_valid2),
    .duration(duration2), .delay_enabled(delay_enabled2), .delay_active(delay_active2),
    .busy(busy2), .done(done2)
  );

  always @(posedge clk) rom_data  <= mem[rom_addr];
  always @(posedge clk) rom_data2 <= mem2[rom_addr2];

  // Delay model: counts enabled cycles, active until duration*PREDIV cycles have elapsed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              dcnt <= '0;
    else if (!delay_enabled) dcnt <= '0;
    else                     dcnt <= dcnt + 13'd1;
  end
  assign delay_active = delay_enabled && (dcnt < {duration, 2'b00});

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               dcnt2 <= '0;
    else if (!delay_enabled2) dcnt2 <= '0;
    else                      dcnt2 <= dcnt2 + 13'd1;
  end
  assign delay_active2 = delay_enabled2 && (dcnt2 < {duration2, 2'b00});

  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt++;
    if (done2 === 1'b1) done2_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits out the low gap, then times one enabled window of the main sequencer.
  task automatic measure(input string tag, input int exp_note, input int exp_gap, input int exp_len);
    int gap, len, nv_bad;
    gap = 0;
    while (!delay_enabled && gap < 50) begin step(); gap++; end
    chk({tag, " gap"}, gap, exp_gap);
    chk({tag, " note"}, note, exp_note);
    len = 0;
    nv_bad = 0;
    while (delay_enabled && len < 200) begin
      if (note_valid !== (exp_note != 0)) nv_bad++;
      step();
      len++;
    end
    chk({tag, " len"}, len, exp_len);
    chk({tag, " note_valid"}, nv_bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = {4'd3, 11'd2};
    mem[1] = {4'd0, 11'd1};
    mem[2] = {4'd5, 11'd3};
    mem[3] = {4'd0, 11'd0};
    for (int i = 0; i < 4; i++) mem2[i] = {4'd1, 11'd1};

    // Reset values
    #1;
    chk("rst busy", busy, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst note", note, 0);
    chk("rst duration", duration, 0);
    chk("rst delay_enabled", delay_enabled, 0);
    chk("rst note_valid", note_valid, 0);
    chk("rst done", done, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Basic song: 3,0,5 then end marker
    base = done_cnt;
    pulse_start();
    chk("t1 busy after start", busy, 1);
    measure("t1 n3", 3, 2, 9);
    measure("t1 n0", 0, 3, 5);
    measure("t1 n5", 5, 3, 13);
    step();
    chk("t1 done early", done, 0);
    step();
    step();
    chk("t1 done pulse", done, 1);
    chk("t1 busy at done", busy, 0);
    step();
    chk("t1 done one cycle", done, 0);
    chk("t1 idle", busy, 0);
    chk("t1 done count", done_cnt - base, 1);

    // Looping: three passes, loop restart gap is 5
    base = done_cnt;
    loop = 1'b1;
    pulse_start();
    measure("t2 p1 n3", 3, 2, 9);
    measure("t2 p1 n0", 0, 3, 5);
    measure("t2 p1 n5", 5, 3, 13);
    for (int p = 2; p <= 3; p++) begin
      measure($sformatf("t2 p%0d n3", p), 3, 5, 9);
      chk($sformatf("t2 p%0d addr", p), rom_addr, 0);
      measure($sformatf("t2 p%0d n0", p), 0, 3, 5);
      measure($sformatf("t2 p%0d n5", p), 5, 3, 13);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop = 1'b0;
    step();
    chk("t2 no done", done_cnt - base, 0);
    chk("t2 idle after stop", busy, 0);

    // End marker at address 0 with loop set
    base = done_cnt;
    mem[0] = '0;
    loop = 1'b1;
    pulse_start();
    chk("t3 fetch en", delay_enabled, 0);
    step();
    chk("t3 load en", delay_enabled, 0);
    chk("t3 load done", done, 0);
    step();
    chk("t3 done pulse", done, 1);
    chk("t3 busy", busy, 0);
    chk("t3 en", delay_enabled, 0);
    step();
    chk("t3 done count", done_cnt - base, 1);
    loop = 1'b0;
    mem[0] = {4'd3, 11'd2};

    // Stop in the middle of the second note
    base = done_cnt;
    pulse_start();
    measure("t4 n3", 3, 2, 9);
    begin
      int g;
      g = 0;
      while (!delay_enabled && g < 10) begin step(); g++; end
      chk("t4 gap", g, 3);
    end
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t4 busy", busy, 0);
    chk("t4 en", delay_enabled, 0);
    chk("t4 addr", rom_addr, 0);
    chk("t4 note", note, 0);
    chk("t4 nv", note_valid, 0);
    step();
    step();
    chk("t4 no done", done_cnt - base, 0);
    pulse_start();
    measure("t4 restart n3", 3, 2, 9);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();

    // Asynchronous reset mid-PLAY, then start re-pulsed while busy
    pulse_start();
    measure("t5 n3", 3, 2, 9);
    while (!delay_enabled && busy) step();
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("t5 busy", busy, 0);
    chk("t5 en", delay_enabled, 0);
    chk("t5 nv", note_valid, 0);
    chk("t5 note", note, 0);
    chk("t5 dur", duration, 0);
    chk("t5 addr", rom_addr, 0);
    chk("t5 done", done, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    step();
    chk("t5 stays idle", busy, 0);
    base = done_cnt;
    pulse_start();
    measure("t5 n3 again", 3, 2, 9);
    start = 1'b1;
    measure("t5 n0 start held", 0, 3, 5);
    start = 1'b0;
    measure("t5 n5", 5, 3, 13);
    step();
    step();
    step();
    chk("t5 done pulse", done, 1);
    step();
    chk("t5 done count", done_cnt - base, 1);

    // ADDR_W=2: address wraps 3->0 with no end implied
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int gap, len;
      gap = 0;
      while (!delay_enabled2 && gap < 50) begin step(); gap++; end
      chk($sformatf("t6 gap %0d", i), gap, (i == 0) ? 2 : 3);
      chk($sformatf("t6 addr %0d", i), rom_addr2, i % 4);
      chk($sformatf("t6 note %0d", i), note2, 1);
      len = 0;
      while (delay_enabled2 && len < 200) begin step(); len++; end
      chk($sformatf("t6 len %0d", i), len, 5);
    end
    chk("t6 busy", busy2, 1);
    chk("t6 no done", done2_cnt, 0);
    stop2 = 1'b1;
    step();
    stop2 = 1'b0;
    chk("t6 stopped", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Song sequencer for the music player: walks a synchronous note ROM, presents each note's tone index to the tone generator, and times it with the `delay` block by driving its `duration`/`enabled` inputs and watching its `active` output. It is the initiator side of the delay handshake. It supports start, stop, end-of-song markers, rests, and optional looping.

## Interface
- `WIDTH`, 11: duration width; matches `delay` `WIDTH`; units are delay ticks (512 Hz).
- `NOTE_W`, 4: tone index width; index 0 = rest (silence).
- `ADDR_W`, 6: ROM address width.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each cycle; starts playback from address 0 when in IDLE, otherwise ignored.
- `stop`  in  1  abort playback; priority over everything except reset.
- `loop`  in  1  at end marker, restart from address 0 instead of finishing.
- `rom_addr`  out  ADDR_W  ROM address, registered.
- `rom_data`  in  NOTE_W+WIDTH  word {note, duration}; valid the cycle after `rom_addr` has been stable for one cycle (1-cycle synchronous ROM).
- `note`  out  NOTE_W  tone index of the current note.
- `note_valid`  out  1  tone generator enable; high only in PLAY with `note != 0`.
- `duration`  out  WIDTH  to `delay.duration`.
- `delay_enabled`  out  1  to `delay.enabled`.
- `delay_active`  in  1  from `delay.active`; combinational from `delay_enabled`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a song ends normally.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, REST.
- IDLE:
  - If `start`: `rom_addr`<=0, go to FETCH.
- FETCH:
  - Hold `rom_addr` for one cycle, then go to LOAD.
- LOAD:
  - Capture `rom_data` into `note`/`duration`.
  - If duration == 0, the word is an end marker:
    - If `loop` and `rom_addr != 0`: `rom_addr`<=0, go to FETCH.
    - Otherwise: pulse `done`, go to IDLE.
    - An end marker at address 0 always ends the song; this prevents an infinite empty loop.
  - Else: go to PLAY.
- PLAY:
  - `delay_enabled`=1; `note_valid` = (`note != 0`).
  - Each cycle, sample `delay_active`. The first PLAY cycle sees `delay_active`=1 because duration is nonzero.
  - When `delay_active`==0: go to REST.
- REST:
  - `delay_enabled`=0 and `note_valid`=0 for exactly one cycle, which clears the delay counter.
  - `rom_addr`<=`rom_addr`+1, wrapping from 2^ADDR_W-1 to 0.
  - Go to FETCH. After a wrap, playback continues from 0 with no end marker implied.
- `stop` high in any state: next state is IDLE; `delay_enabled`, `note_valid`, `done` go low; `rom_addr`, `note` and `duration` go to 0. `done` is not pulsed.
- `start` and `stop` high together in IDLE: remain in IDLE.
- Registers:
  - All outputs are registered except `busy`, which is decoded from state.
  - No output glitches.

## Timing
- Reset values: state IDLE; `rom_addr`=0, `note`=0, `duration`=0, `delay_enabled`=0, `note_valid`=0, `done`=0, `busy`=0.
- Reset asserted mid-song: all outputs return to reset values immediately (asynchronous). Playback resumes only on a new `start`.
- `start` is sampled at edge E0. Then FETCH runs during E0..E1 and LOAD during E1..E2. `delay_enabled`/`note_valid` go high after E2, i.e. 2 cycles after the start edge.
- Note length: `duration`·PREDIV cycles in PLAY, as counted by `delay`, plus 1 cycle for the `active` fall to be sampled.
- Inter-note gap: 3 cycles with `delay_enabled` low (REST, FETCH, LOAD).
- Loop restart adds 2 cycles (LOAD of the marker, then FETCH), in addition to the normal gap.
- `done` rises on the edge leaving LOAD, lasts one cycle, and coincides with `busy` falling.

## Test plan
- Bench setup: `delay` instantiated with PREDIV=4, WIDTH=11. ROM holds {3,2},{0,1},{5,3},{0,0}. Pulse `start`.
  - Required: `note` sequence 3, 0, 5.
  - Required `delay_enabled` high times: 9, 5, 13 cycles.
  - Required: `note_valid` low during the rest note; 3-cycle gaps between notes; a single `done` pulse; then IDLE with `busy`=0.
- Same ROM with `loop`=1: after note 5, `rom_addr` returns to 0 and note 3 replays. `done` is never asserted across 3 passes.
- ROM word 0 = {0,0}, `loop`=1, pulse `start`: `done` pulses 2 cycles after start; no PLAY; IDLE.
- Assert `stop` in the middle of PLAY of the second note: next cycle IDLE, `delay_enabled`=0, `rom_addr`=0, no `done`. A new `start` replays from note 3.
- Deassert `rst_n` asynchronously mid-PLAY, off a clock edge: outputs reach reset values before the next edge. Re-pulse `start` while `busy`: ignored; sequence unchanged.
- ADDR_W=2, all four words nonzero {1,1}: `rom_addr` wraps 3->0 and playback continues indefinitely with no `done`.
